pipe_hazard_ctrl: RTL

Pipeline hazard and redirect controller for the five-stage core. It generates the `hold_flag`/`jump_flag` pair consumed by the ID/EX register, plus the PC and IF/ID stall/flush controls. It also issues whole-front-end freezes while a data-memory access is outstanding. It sits beside the pipeline: it takes decode, EX and MEM status and drives control back into every upstream pipeline register.

---
 rtl/pipe_hazard_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use, redirect and data-memory stall controller for the five-stage core
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CPU_WIDTH      = 32,
  parameter int FLUSH_CYCLES   = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_wreg_addr,
  input  logic                      jump_req,
  input  logic [CPU_WIDTH-1:0]      jump_target,
  input  logic                      dmem_req,
  input  logic                      dmem_ready,
  output logic                      pc_hold,
  output logic                      if_id_hold,
  output logic                      if_id_flush,
  output logic                      hold_flag,
  output logic                      jump_flag,
  output logic                      id_ex_freeze,
  output logic                      ex_mem_hold,
  output logic                      pc_jump_en,
  output logic [CPU_WIDTH-1:0]      pc_jump_addr,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  state_t     state, state_nxt;
  logic [2:0] flush_rem, flush_rem_nxt;
  logic       lu, ms;

  assign lu = ex_mem_read && (ex_wreg_addr != '0) &&
              ((id_use_rs1 && (id_rs1 == ex_wreg_addr)) ||
               (id_use_rs2 && (id_rs2 == ex_wreg_addr)));
  assign ms = dmem_req && !dmem_ready;

  assign pc_jump_addr = pc_jump_en ? jump_target : '0;

  // Outputs are gated by rstn so an asserted reset silences them even while inputs still request a stall.
  always_comb begin
    state_nxt     = state;
    flush_rem_nxt = flush_rem;
    pc_hold       = 1'b0;
    if_id_hold    = 1'b0;
    if_id_flush   = 1'b0;
    hold_flag     = 1'b0;
    jump_flag     = 1'b0;
    id_ex_freeze  = 1'b0;
    ex_mem_hold   = 1'b0;
    pc_jump_en    = 1'b0;
    if (rstn) begin
      case (state)
        RUN: begin
          if (ms) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_freeze = 1'b1;
            ex_mem_hold  = 1'b1;
            state_nxt    = MEM_WAIT;
          end else if (jump_req) begin
            pc_jump_en  = 1'b1;
            if_id_flush = 1'b1;
            jump_flag   = 1'b1;
            if (FLUSH_INIT != 3'd0) begin
              flush_rem_nxt = FLUSH_INIT;
              state_nxt     = FLUSH;
            end
          end else if (lu) begin
            pc_hold    = 1'b1;
            if_id_hold = 1'b1;
            hold_flag  = 1'b1;
          end
        end
        MEM_WAIT: begin
          // EX is frozen here, so any jump or load-use it shows is re-presented after the release.
          if (!dmem_ready) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_freeze = 1'b1;
            ex_mem_hold  = 1'b1;
          end else begin
            state_nxt = (flush_rem != 3'd0) ? FLUSH : RUN;
          end
        end
        FLUSH: begin
          if (ms) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_freeze = 1'b1;
            ex_mem_hold  = 1'b1;
            state_nxt    = MEM_WAIT;
          end else if (jump_req) begin
            pc_jump_en    = 1'b1;
            if_id_flush   = 1'b1;
            jump_flag     = 1'b1;
            flush_rem_nxt = FLUSH_INIT;
          end else begin
            if_id_flush   = 1'b1;
            jump_flag     = 1'b1;
            flush_rem_nxt = flush_rem - 3'd1;
            if (flush_rem <= 3'd1) begin
              flush_rem_nxt = 3'd0;
              state_nxt     = RUN;
            end
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= RUN;
      flush_rem <= 3'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_rem <= flush_rem_nxt;
      if (pc_hold && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (pc_jump_en && (flush_cnt != 32'hFFFF_FFFF))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end

endmodule
